// File: rtl/psum_accumulator_pkg.sv
// Shared widths and state encoding for the partial-sum accumulator and its helpers.
package psum_accumulator_pkg;

  localparam int unsigned BITS_SIP_DOT_ADDER = 20;
  localparam int unsigned BITS_PSUM_ACC      = BITS_SIP_DOT_ADDER + 16;

  typedef enum logic [1:0] {
    PACC_IDLE = 2'd0,
    PACC_ACC  = 2'd1,
    PACC_HOLD = 2'd2
  } pacc_state_e;

endpackage

// File: rtl/psum_shift_ext.sv
// Sign-extends a partial sum to the accumulator width and weights it by 2^(2k).
module psum_shift_ext #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 24
) (
  input  logic signed [W_IN-1:0]  psum,
  input  logic        [2:0]       shift,
  output logic signed [W_OUT-1:0] term
);

  logic signed [W_OUT-1:0] ext;

  assign ext  = W_OUT'(psum);
  assign term = ext <<< {shift, 1'b0};

endmodule

// File: rtl/psum_accumulator.sv
// Shift-accumulates PE partial sums per group and hands the result out via valid/ready.
// Build option: define PSUM_ACC_SAT_EN for saturating adds with a sticky per-group clamp.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int W_PSUM = BITS_SIP_DOT_ADDER,
  parameter int W_ACC  = W_PSUM + 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic signed [W_PSUM-1:0] i_PSUM,
  input  logic                     i_Valid,
  input  logic        [2:0]        i_Shift,
  input  logic                     i_First,
  input  logic                     i_Last,
  output logic                     o_InReady,
  output logic signed [W_ACC-1:0]  o_Acc,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic                     o_Overrun
);

  pacc_state_e             state_q;
  logic signed [W_ACC-1:0] acc_q, acc_d, base, term;
  logic                    accept, restart;

  psum_shift_ext #(
    .W_IN  (W_PSUM),
    .W_OUT (W_ACC)
  ) u_shift_ext (
    .psum  (i_PSUM),
    .shift (i_Shift),
    .term  (term)
  );

  assign o_InReady = (state_q != PACC_HOLD) || i_Ready;
  assign accept    = i_Valid && o_InReady;
  assign restart   = i_First || (state_q == PACC_IDLE);
  assign base      = restart ? '0 : acc_q;
  assign o_Acc     = acc_q;
  assign o_Valid   = (state_q == PACC_HOLD);

`ifdef PSUM_ACC_SAT_EN
  localparam logic [W_ACC-1:0] AccMax = {1'b0, {(W_ACC-1){1'b1}}};
  localparam logic [W_ACC-1:0] AccMin = {1'b1, {(W_ACC-1){1'b0}}};

  logic             sat_q, sat_d, sat_hold, ovf;
  logic [W_ACC:0]   sum_ext;

  // One guard bit: overflow when the two top bits of the widened sum disagree.
  assign sum_ext  = {base[W_ACC-1], base} + {term[W_ACC-1], term};
  assign ovf      = sum_ext[W_ACC] != sum_ext[W_ACC-1];
  assign sat_hold = sat_q && !restart;
  assign sat_d    = sat_hold || ovf;

  always_comb begin
    acc_d = sum_ext[W_ACC-1:0];
    if (sat_hold) begin
      acc_d = acc_q;
    end else if (ovf) begin
      acc_d = sum_ext[W_ACC] ? AccMin : AccMax;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sat_q <= 1'b0;
    end else if (accept) begin
      sat_q <= sat_d;
    end
  end
`else
  assign acc_d = base + term;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= PACC_IDLE;
      acc_q     <= '0;
      o_Overrun <= 1'b0;
    end else begin
      if (i_Valid && !o_InReady) begin
        o_Overrun <= 1'b1;
      end
      if (accept) begin
        acc_q   <= acc_d;
        state_q <= i_Last ? PACC_HOLD : PACC_ACC;
      end else if (state_q == PACC_HOLD && i_Ready) begin
        state_q <= PACC_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed plus randomized bench for psum_accumulator with a group-level reference model.
module tb_psum_accumulator;

  localparam int W_PSUM = 12;
  localparam int W_ACC  = 20;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b1;
  logic signed [W_PSUM-1:0] i_PSUM = '0;
  logic                     i_Valid = 1'b0;
  logic        [2:0]        i_Shift = '0;
  logic                     i_First = 1'b0;
  logic                     i_Last = 1'b0;
  logic                     i_Ready = 1'b0;
  logic                     o_InReady;
  logic signed [W_ACC-1:0]  o_Acc;
  logic                     o_Valid;
  logic                     o_Overrun;

  psum_accumulator #(
    .W_PSUM (W_PSUM),
    .W_ACC  (W_ACC)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .i_PSUM    (i_PSUM),
    .i_Valid   (i_Valid),
    .i_Shift   (i_Shift),
    .i_First   (i_First),
    .i_Last    (i_Last),
    .o_InReady (o_InReady),
    .o_Acc     (o_Acc),
    .o_Valid   (o_Valid),
    .i_Ready   (i_Ready),
    .o_Overrun (o_Overrun)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: a group is open, or a finished result is pending, or neither.
  bit     m_open, m_pending, m_ovr, m_sat;
  longint m_acc;

  localparam longint Mod    = 64'sd1 <<< W_ACC;
  localparam longint AccMax = (64'sd1 <<< (W_ACC - 1)) - 1;
  localparam longint AccMin = -(64'sd1 <<< (W_ACC - 1));

  function automatic longint wrap(input longint x);
    longint m;
    m = x % Mod;
    if (m < 0) m += Mod;
    if (m > AccMax) m -= Mod;
    return m;
  endfunction

  task automatic model_reset();
    m_open = 0; m_pending = 0; m_ovr = 0; m_sat = 0; m_acc = 0;
  endtask

  task automatic model_clock(input bit v, input longint ps, input int k, input bit f,
                             input bit l, input bit rdy);
    bit     ready, start;
    longint term, base, sum;
    ready = !m_pending || rdy;
    if (v && !ready) m_ovr = 1;
    if (v && ready) begin
      start = f || (!m_open && !m_pending);
      term  = wrap(ps * (64'sd1 <<< (2 * k)));
      base  = start ? 0 : m_acc;
`ifdef PSUM_ACC_SAT_EN
      if (start) m_sat = 0;
      sum = base + term;
      if (!m_sat) begin
        if (sum > AccMax) begin
          m_acc = AccMax; m_sat = 1;
        end else if (sum < AccMin) begin
          m_acc = AccMin; m_sat = 1;
        end else begin
          m_acc = sum;
        end
      end
`else
      sum   = base + term;
      m_acc = wrap(sum);
`endif
      m_pending = l;
      m_open    = !l;
    end else if (m_pending && rdy) begin
      m_pending = 0;
    end
  endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".acc"}, longint'(o_Acc), m_acc);
    chk({tag, ".valid"}, longint'(o_Valid), longint'(m_pending));
    chk({tag, ".overrun"}, longint'(o_Overrun), longint'(m_ovr));
  endtask

  // Drives one beat after the previous edge, checks ready, clocks, then checks outputs.
  task automatic step(input string tag, input bit v, input int psum, input int k,
                      input bit f, input bit l, input bit rdy);
    logic signed [W_PSUM-1:0] p;
    p       = W_PSUM'(psum);
    i_Valid = v;
    i_PSUM  = p;
    i_Shift = 3'(k);
    i_First = f;
    i_Last  = l;
    i_Ready = rdy;
    #1;
    chk({tag, ".in_ready"}, longint'(o_InReady), longint'(!m_pending || rdy));
    @(posedge CLK);
    model_clock(v, longint'(p), k, f, l, rdy);
    #1;
    chk_outputs(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.acc", longint'(o_Acc), 0);
    chk("reset.valid", longint'(o_Valid), 0);
    chk("reset.in_ready", longint'(o_InReady), 1);
    chk("reset.overrun", longint'(o_Overrun), 0);
    RST = 1'b0;

    // Three-term group: 5 - 3*4 + 2*16.
    step("seq0", 1, 5, 0, 1, 0, 1);
    step("seq1", 1, -3, 1, 0, 0, 1);
    step("seq2", 1, 2, 2, 0, 1, 1);
    chk("seq.result", longint'(o_Acc), 25);
    step("seq.drain", 0, 0, 0, 0, 0, 1);
    chk("seq.valid_drop", longint'(o_Valid), 0);

    step("single", 1, -1, 7, 1, 1, 1);
    chk("single.result", longint'(o_Acc), -16384);
    step("single.drain", 0, 0, 0, 0, 0, 1);

    // Hold 25 while downstream stalls and inputs keep arriving.
    step("hold0", 1, 5, 0, 1, 0, 1);
    step("hold1", 1, -3, 1, 0, 0, 1);
    step("hold2", 1, 2, 2, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 9, 3, 1, 0, 0);
      chk("stall.acc", longint'(o_Acc), 25);
    end
    chk("stall.overrun", longint'(o_Overrun), 1);
    // Drain and accept the next group's first beat in the same cycle.
    step("drain_accept", 1, 7, 0, 1, 0, 1);
    chk("drain_accept.acc", longint'(o_Acc), 7);
    chk("drain_accept.overrun", longint'(o_Overrun), 1);

    // Two large same-sign terms overflow the accumulator.
    step("ovf0", 1, 2047, 4, 1, 0, 1);
    step("ovf1", 1, 2047, 4, 0, 1, 1);
`ifdef PSUM_ACC_SAT_EN
    chk("ovf.result", longint'(o_Acc), 524287);
`else
    chk("ovf.result", longint'(o_Acc), -512);
`endif
    step("ovf.drain", 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset between clock edges while a group is open.
    step("pre_rst", 1, 3, 0, 1, 0, 1);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk("async_rst.acc", longint'(o_Acc), 0);
    chk("async_rst.valid", longint'(o_Valid), 0);
    chk("async_rst.in_ready", longint'(o_InReady), 1);
    chk("async_rst.overrun", longint'(o_Overrun), 0);
    #1;
    RST = 1'b0;
    step("post_rst", 1, 1, 0, 1, 1, 1);
    chk("post_rst.result", longint'(o_Acc), 1);
    step("post_rst.drain", 0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream stage of the processing element: takes its registered signed partial sum each cycle and shift-accumulates it into a full-precision output. The shift compensates for the position of the 2-bit activation/weight slices that produced the partial sum. On the last partial sum of a group, the block presents the result with a valid/ready handshake to the output buffer. One instance sits behind each PE column.

## Interface
- W_PSUM, default `BITS_SIP_DOT_ADDER: width of the incoming signed partial sum.
- W_ACC, default W_PSUM+16: width of the signed accumulator and result.
- CLK  input  1: clock, rising edge.
- RST  input  1: reset, asynchronous, active-high.
- i_PSUM  input  W_PSUM: signed partial sum from the PE, already registered.
- i_Valid  input  1: i_PSUM is valid this cycle.
- i_Shift  input  3: slice position k; the partial sum is weighted by 2^(2k), so shifts of 0..14.
- i_First  input  1: this partial sum starts a new group and discards the old accumulator.
- i_Last  input  1: this partial sum closes the group.
- o_InReady  output  1: the block accepts i_Valid this cycle.
- o_Acc  output  W_ACC: signed result, held stable while o_Valid is high.
- o_Valid  output  1: o_Acc is a completed group.
- i_Ready  input  1: the downstream side accepts o_Acc.
- o_Overrun  output  1: sticky flag, set when i_Valid arrives while o_InReady is low.

## Operation
- States:
  - IDLE: no open group.
  - ACC: group open.
  - HOLD: result waiting for i_Ready.
- Acceptance:
  - accept = i_Valid && o_InReady.
  - o_InReady = (state != HOLD) || i_Ready, which allows the result to drain and a new input to be accepted in the same cycle.
- Term: sign-extend i_PSUM to W_ACC, then arithmetic left shift by 2*i_Shift.
- Accumulation on accept: acc <= (i_First || state==IDLE ? 0 : acc) + term.
  - i_First is implied when starting from IDLE.
  - i_First in ACC silently restarts the group.
- Transitions:
  - IDLE/ACC/HOLD with accept and !i_Last -> ACC.
  - Accept with i_Last -> HOLD, and o_Valid rises. i_First together with i_Last gives a single-term group.
  - HOLD with i_Ready and no accept -> IDLE.
  - HOLD with i_Ready and accept -> ACC or HOLD, decided by i_Last.
  - HOLD without i_Ready: o_Acc and state are frozen. Any i_Valid in this state is dropped and sets o_Overrun.
- o_Acc is the accumulator register itself; there is no separate output copy.
- Overflow: the sum wraps modulo 2^W_ACC unless saturation is compiled in (see Configuration).
- o_Overrun clears only on RST.

## Timing
- Reset values: state IDLE, acc 0, o_Acc 0, o_Valid 0, o_InReady 1, o_Overrun 0.
- Latency: result visible on o_Acc/o_Valid one cycle after the accepted i_Last beat.
- Throughput: one partial sum per cycle. A back-to-back group with i_First right after i_Last sees no bubble when i_Ready is high.
- RST mid-group or during HOLD: the result is lost and the state returns to IDLE immediately, with no handshake completion.
- o_InReady is combinational from state and i_Ready. There is no combinational path from i_PSUM to any output.

## Configuration
- PSUM_ACC_SAT_EN defined:
  - Each add saturates to [-2^(W_ACC-1), 2^(W_ACC-1)-1].
  - A sticky per-group flag forces o_Acc to the saturated bound for the rest of the group, so a later opposite-sign term cannot unsaturate it.
  - The flag clears on the next group start.
- Not defined: two's-complement wrap, and no extra logic.

## Structure
- Shared defines file holds:
  - `BITS_SIP_DOT_ADDER;
  - a new `BITS_PSUM_ACC (= `BITS_SIP_DOT_ADDER+16);
  - state encodings `PACC_IDLE, `PACC_ACC, `PACC_HOLD.
- One natural sub-module, psum_shift_ext: combinational sign-extend plus shift by 2*k, reusable by the column reducer.
- Registers are plain always blocks with async reset. DFFQ has no reset and is not usable here.

## Test plan
- Sequence (5, k0, first) -> (-3, k1) -> (2, k2, last), i_Ready=1: o_Valid for one cycle with o_Acc = 5-12+32 = 25.
- Single beat (-1, k7, first+last): o_Acc = -16384.
- Hold o_Acc=25 with i_Ready=0 for 3 cycles while i_Valid pulses:
  - o_Acc stays 25 and o_InReady stays 0;
  - o_Overrun=1 and stays 1 after the drain.
- i_Ready high together with the i_First beat of the next group (7, k0): the old result is drained, the new accumulator becomes 7, and there is no stall.
- With W_PSUM=8, W_ACC=12, add 127 at k2 (shift 4) twice:
  - with PSUM_ACC_SAT_EN, o_Acc = 2047;
  - without it, o_Acc = 4064 mod 4096 = -32.
- Assert RST asynchronously mid-group (between clock edges): all outputs immediately read reset values, then a new group (1, k0, first+last) gives o_Acc = 1.
